// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - time-multiplexed N-digit seven-segment scan driver (optional SSD_LZB_EN leading-zero blanking)
module ssd_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE_BITS = 18,
    parameter int BLANK_CYCLES  = 16
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [4*NUM_DIGITS-1:0]   Data,
    input  logic [NUM_DIGITS-1:0]     Dp_In,
    input  logic [NUM_DIGITS-1:0]     Digit_En,
    input  logic                      Load,
    output logic                      Pending,
    output logic                      Frame_Tick,
    output logic [NUM_DIGITS-1:0]     An,
    output logic [7:0]                Cathodes
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESCALE_BITS-1:0] BLANK_LIM = PRESCALE_BITS'(BLANK_CYCLES);

    logic [PRESCALE_BITS-1:0] slot_cnt;
    logic [IDX_W-1:0]         digit_idx;
    logic                     slot_wrap;
    logic                     frame_edge;

    logic [4*NUM_DIGITS-1:0]  pend_data;
    logic [NUM_DIGITS-1:0]    pend_dp;
    logic [NUM_DIGITS-1:0]    pend_en;
    logic                     pend_flag;

    logic [4*NUM_DIGITS-1:0]  disp_data;
    logic [NUM_DIGITS-1:0]    disp_dp;
    logic [NUM_DIGITS-1:0]    disp_en;

    logic [NUM_DIGITS-1:0]    blank_mask;
    logic [3:0]               cur_nib;
    logic                     cur_dp;
    logic                     cur_en;
    logic                     cur_blank;
    logic                     lit;
    logic [NUM_DIGITS-1:0]    an_next;
    logic [7:0]               cat_next;

    assign slot_wrap  = &slot_cnt;
    assign frame_edge = slot_wrap && (digit_idx == LAST_IDX);
    assign Pending    = pend_flag;

    // Hex font, segments abcdefg, active-low.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Slot counter free-runs; the digit index steps on every slot wrap.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_wrap) begin
                digit_idx <= frame_edge ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Double buffer: Load fills the pending side, the frame edge publishes it.
    // A Load on the frame edge itself bypasses straight into the display side.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            pend_flag <= 1'b0;
            disp_data <= '0;
            disp_dp   <= '0;
            disp_en   <= '0;
        end else begin
            if (Load) begin
                pend_data <= Data;
                pend_dp   <= Dp_In;
                pend_en   <= Digit_En;
            end
            if (frame_edge) begin
                pend_flag <= 1'b0;
                if (Load) begin
                    disp_data <= Data;
                    disp_dp   <= Dp_In;
                    disp_en   <= Digit_En;
                end else if (pend_flag) begin
                    disp_data <= pend_data;
                    disp_dp   <= pend_dp;
                    disp_en   <= pend_en;
                end
            end else if (Load) begin
                pend_flag <= 1'b1;
            end
        end
    end

`ifdef SSD_LZB_EN
    logic above_blank;

    // Blank zero nibbles from the top down until the first significant enabled digit.
    always_comb begin
        blank_mask  = '0;
        above_blank = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (disp_en[i]) begin
                blank_mask[i] = above_blank && (disp_data[4*i +: 4] == 4'h0);
                above_blank   = blank_mask[i];
            end
        end
    end
`else
    assign blank_mask = '0;
`endif

    // Select the display-buffer fields of the digit currently being scanned.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib   = disp_data[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_en    = disp_en[i];
                cur_blank = blank_mask[i];
            end
        end
    end

    // Anode and cathode values for the current index/counter, before registering.
    always_comb begin
        lit      = cur_en && (slot_cnt >= BLANK_LIM);
        an_next  = '1;
        cat_next = 8'hFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (digit_idx == IDX_W'(i))) begin
                an_next[i] = 1'b0;
            end
        end
        if (lit) begin
            cat_next = {(cur_blank ? 7'h7F : hex_font(cur_nib)), ~cur_dp};
        end
    end

    // Pin-facing outputs are registered so the board sees glitch-free levels.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            An         <= '1;
            Cathodes   <= 8'hFF;
            Frame_Tick <= 1'b0;
        end else begin
            An         <= an_next;
            Cathodes   <= cat_next;
            Frame_Tick <= frame_edge;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - randomized self-checking bench for ssd_scan_driver
module tb_ssd_scan_driver;

    localparam int ND    = 4;
    localparam int PB    = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = 1 << PB;
    localparam int FRAME = SLOT * ND;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] Data;
    logic [3:0]  Dp_In;
    logic [3:0]  Digit_En;
    logic        Load;
    logic        Pending;
    logic        Frame_Tick;
    logic [3:0]  An;
    logic [7:0]  Cathodes;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state: time since reset release plus the two buffers
    int          m_t;
    logic [15:0] m_pdata, m_ddata;
    logic [3:0]  m_pdp, m_ddp, m_pen, m_den;
    logic        m_pend;
    logic [3:0]  exp_an;
    logic [7:0]  exp_cat;
    logic        exp_tick;

    logic [6:0] font_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    ssd_scan_driver #(
        .NUM_DIGITS    (ND),
        .PRESCALE_BITS (PB),
        .BLANK_CYCLES  (BLANK)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Data       (Data),
        .Dp_In      (Dp_In),
        .Digit_En   (Digit_En),
        .Load       (Load),
        .Pending    (Pending),
        .Frame_Tick (Frame_Tick),
        .An         (An),
        .Cathodes   (Cathodes)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at t=%0d: got %h expected %h", tag, m_t, obs, exp);
    endtask

    // a digit is blanked when every enabled digit from it upward holds zero
    function automatic bit digit_blank(input int ix);
`ifdef SSD_LZB_EN
        if (ix == 0) return 1'b0;
        for (int j = ix; j < ND; j++) begin
            if (m_den[j] && (m_ddata[4*j +: 4] != 4'h0)) return 1'b0;
        end
        return 1'b1;
`else
        return (ix < 0);
`endif
    endfunction

    task automatic model_reset();
        m_t = 0;
        m_pdata = '0; m_ddata = '0;
        m_pdp = '0; m_ddp = '0; m_pen = '0; m_den = '0;
        m_pend = 1'b0;
        exp_an = 4'hF; exp_cat = 8'hFF; exp_tick = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                              input logic [3:0] en);
        int  cnt, ix;
        bit  bnd, on;
        logic [3:0] nib;
        cnt = m_t % SLOT;
        ix  = (m_t / SLOT) % ND;
        bnd = (m_t % FRAME) == FRAME - 1;
        on  = m_den[ix] && (cnt >= BLANK);
        exp_an  = 4'hF;
        exp_cat = 8'hFF;
        if (on) begin
            exp_an[ix] = 1'b0;
            nib = m_ddata[4*ix +: 4];
            exp_cat = {(digit_blank(ix) ? 7'h7F : font_tab[nib]), ~m_ddp[ix]};
        end
        exp_tick = bnd;
        if (bnd) begin
            if (ld) begin
                m_ddata = d; m_ddp = dp; m_den = en;
            end else if (m_pend) begin
                m_ddata = m_pdata; m_ddp = m_pdp; m_den = m_pen;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
        end
        if (ld) begin
            m_pdata = d; m_pdp = dp; m_pen = en;
        end
        m_t++;
    endtask

    // drive at the falling edge, model the rising edge, compare at the next falling edge
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                        input logic [3:0] en);
        Load = ld; Data = d; Dp_In = dp; Digit_En = en;
        @(posedge Clk);
        model_edge(ld, d, dp, en);
        @(negedge Clk);
        check("an", An, exp_an);
        check("cathodes", Cathodes, exp_cat);
        check("frame_tick", Frame_Tick, exp_tick);
        check("pending", Pending, m_pend);
    endtask

    task automatic idle();
        step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic run_until(input int target);
        while (m_t < target) idle();
    endtask

    int ticks;

    initial begin
        Reset_n = 1'b0; Load = 1'b0; Data = '0; Dp_In = '0; Digit_En = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_an", An, 4'hF);
        check("rst_cat", Cathodes, 8'hFF);
        check("rst_pending", Pending, 1'b0);
        check("rst_tick", Frame_Tick, 1'b0);
        Reset_n = 1'b1;

        // load and scan
        step(1'b1, 16'h12AF, 4'b0100, 4'hF);
        check("load_pending", Pending, 1'b1);
        run_until(63);
        check("pending_hold", Pending, 1'b1);
        run_until(64);
        check("boundary_pending", Pending, 1'b0);
        check("boundary_tick", Frame_Tick, 1'b1);
        run_until(70);
        check("slot0_an", An, 4'b1110);
        check("slot0_cat", Cathodes, 8'b01110001);
        // dead time at the start of slot 1
        run_until(81);
        check("dead0_an", An, 4'hF);
        run_until(82);
        check("dead1_an", An, 4'hF);
        run_until(83);
        check("dead_end_an", An, 4'b1101);
        run_until(102);
        check("slot2_an", An, 4'b1011);
        check("slot2_cat", Cathodes, 8'b00100100);

        // double load: last wins
        run_until(130);
        step(1'b1, 16'h1111, 4'h0, 4'hF);
        idle();
        step(1'b1, 16'h2222, 4'h0, 4'hF);
        run_until(198);
        check("dbl_d0_cat", Cathodes, 8'b00100101);
        run_until(230);
        check("dbl_d2_cat", Cathodes, 8'b00100101);

        // load on the boundary edge shows this frame, Pending stays 0
        run_until(255);
        step(1'b1, 16'h3333, 4'h0, 4'hF);
        check("bnd_load_pending", Pending, 1'b0);
        check("bnd_load_tick", Frame_Tick, 1'b1);
        run_until(262);
        check("bnd_load_cat", Cathodes, 8'b00001101);

        // disabled digits keep their anodes dark
        run_until(300);
        step(1'b1, 16'h4444, 4'h0, 4'b0101);
        run_until(320);
        for (int k = 0; k < FRAME; k++) begin
            idle();
            check("an13_off", {An[3], An[1]}, 2'b11);
        end

        // leading zeros
        step(1'b1, 16'h0030, 4'h0, 4'hF);
        run_until(454);
        check("lz_d0", Cathodes, 8'b00000011);
        run_until(470);
        check("lz_d1", Cathodes, 8'b00001101);
`ifdef SSD_LZB_EN
        run_until(486);
        check("lz_d2", Cathodes, 8'hFF);
        run_until(502);
        check("lz_d3", Cathodes, 8'hFF);
`else
        run_until(486);
        check("lz_d2", Cathodes, 8'b00000011);
        run_until(502);
        check("lz_d3", Cathodes, 8'b00000011);
`endif

        // randomized traffic against the model
        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(11) == 0)
                step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
            else
                idle();
        end

        // asynchronous reset mid-slot
        step(1'b1, 16'h8888, 4'hF, 4'hF);
        #2;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_an", An, 4'hF);
        check("mid_rst_cat", Cathodes, 8'hFF);
        check("mid_rst_pending", Pending, 1'b0);
        check("mid_rst_tick", Frame_Tick, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        ticks = 0;
        for (int k = 0; k < FRAME - 1; k++) begin
            idle();
            ticks += Frame_Tick;
        end
        check("no_tick_after_rst", ticks, 0);
        idle();
        check("first_tick_after_rst", Frame_Tick, 1'b1);
        run_until(3 * FRAME + 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
